recv_send: RTL and testbench

//  Responder end of the one-byte serial exchange: waits for a byte from the RX UART,

---
 rtl/serial_pkg.sv | 21 ++
 rtl/resp_timer.sv | 32 +++
 rtl/recv_send.sv | 120 ++++++++++++
 tb/tb_recv_send.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the one-byte serial responder: FSM encodings,
// default NAK byte and the timeout-timer width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    TX_WAIT   = 2'd2,
    TX_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] DEFAULT_NAK_CHAR = 8'h15;

  // Bits needed to count up to limit inclusive; never narrower than one bit.
  function automatic int timer_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/resp_timer.sv
// Response-wait timer: counts enabled cycles from a clear and flags the cycle
// in which the count reaches LIMIT-1. LIMIT=0 disables expiry entirely.
module resp_timer
  import serial_pkg::*;
#(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timer_width(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);
  localparam logic [W-1:0] SAT  = W'(LIMIT);

  logic [W-1:0] count_reg;

  // Saturates at LIMIT so a stalled count can never wrap back into range.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != SAT)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign expired = enable && (LIMIT != 0) && (count_reg == LAST);

endmodule

// File: rtl/recv_send.sv
// Responder end of the one-byte serial exchange: takes a byte from the RX UART,
// offers it to user logic, and transmits the response (or NAK on timeout).
module recv_send
  import serial_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] NAK_CHAR       = DEFAULT_NAK_CHAR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_rd_strobe,
  output logic [7:0] tx_data,
  output logic       tx_wr_strobe,
  input  logic       tx_busy,
  output logic [7:0] req_data,
  output logic       req_valid,
  input  logic [7:0] resp_data,
  input  logic       resp_valid,
  output logic       busy,
  output logic       timeout_err
);

  state_t     state_reg, state_next;
  logic [7:0] req_data_reg, req_data_next;
  logic [7:0] out_byte_reg, out_byte_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic       rx_rd_strobe_reg, rx_rd_strobe_next;
  logic       req_valid_reg, req_valid_next;
  logic       tx_wr_strobe_reg, tx_wr_strobe_next;
  logic       timeout_err_reg, timeout_err_next;
  logic       timer_expired;

  resp_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_reg == IDLE),
    .enable  (state_reg == WAIT_RESP),
    .expired (timer_expired)
  );

  always_comb begin
    state_next        = state_reg;
    req_data_next     = req_data_reg;
    out_byte_next     = out_byte_reg;
    tx_data_next      = tx_data_reg;
    rx_rd_strobe_next = 1'b0;
    req_valid_next    = 1'b0;
    tx_wr_strobe_next = 1'b0;
    timeout_err_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rx_valid) begin
          req_data_next     = rx_data;
          rx_rd_strobe_next = 1'b1;
          req_valid_next    = 1'b1;
          state_next        = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        // A response arriving on the expiry cycle still wins over the NAK.
        if (resp_valid) begin
          out_byte_next = resp_data;
          state_next    = TX_WAIT;
        end else if (timer_expired) begin
          out_byte_next    = NAK_CHAR;
          timeout_err_next = 1'b1;
          state_next       = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (!tx_busy) begin
          tx_data_next      = out_byte_reg;
          tx_wr_strobe_next = 1'b1;
          state_next        = TX_DONE;
        end
      end
      TX_DONE: begin
        // Dead cycle lets the UART raise tx_busy before we could strobe again.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      req_data_reg     <= '0;
      out_byte_reg     <= '0;
      tx_data_reg      <= '0;
      rx_rd_strobe_reg <= 1'b0;
      req_valid_reg    <= 1'b0;
      tx_wr_strobe_reg <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      req_data_reg     <= req_data_next;
      out_byte_reg     <= out_byte_next;
      tx_data_reg      <= tx_data_next;
      rx_rd_strobe_reg <= rx_rd_strobe_next;
      req_valid_reg    <= req_valid_next;
      tx_wr_strobe_reg <= tx_wr_strobe_next;
      timeout_err_reg  <= timeout_err_next;
    end
  end

  assign rx_rd_strobe = rx_rd_strobe_reg;
  assign req_valid    = req_valid_reg;
  assign req_data     = req_data_reg;
  assign tx_data      = tx_data_reg;
  assign tx_wr_strobe = tx_wr_strobe_reg;
  assign timeout_err  = timeout_err_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_recv_send.sv
// Scoreboard bench for recv_send: directed exchanges push expected requests and
// transmitted bytes (with latency from req_valid); a negedge monitor checks them.
module tb_recv_send;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_rd_strobe;
  logic [7:0] tx_data;
  logic       tx_wr_strobe;
  logic       tx_busy;
  logic [7:0] req_data;
  logic       req_valid;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       busy;
  logic       timeout_err;

  recv_send #(
    .TIMEOUT_CYCLES (TO),
    .NAK_CHAR       (8'h15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_rd_strobe (rx_rd_strobe),
    .tx_data      (tx_data),
    .tx_wr_strobe (tx_wr_strobe),
    .tx_busy      (tx_busy),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .resp_data    (resp_data),
    .resp_valid   (resp_valid),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } exp_tx_t;

  exp_tx_t    exp_tx[$];
  logic [7:0] exp_req[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int last_rd_cyc = 0;
  int rd_count = 0;
  int req_count = 0;
  int tx_count = 0;
  int to_count = 0;
  logic prev_tx_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_rd_strobe || req_valid)
        check("rd_strobe_with_req_valid", {31'd0, rx_rd_strobe}, {31'd0, req_valid});
      if (rx_rd_strobe) begin
        if (rd_count > 0)
          check("rd_spacing_ge4", {31'd0, (cyc - last_rd_cyc) >= 4}, 32'd1);
        rd_count++;
        last_rd_cyc = cyc;
      end
      if (req_valid) begin
        req_count++;
        req_cyc = cyc;
        if (exp_req.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          logic [7:0] e;
          e = exp_req.pop_front();
          $display("req  #%0d data %02h (expect %02h) cycle %0d", req_count, req_data, e, cyc);
          check("req_data", {24'd0, req_data}, {24'd0, e});
        end
      end
      if (timeout_err) begin
        to_count++;
        check("timeout_latency", cyc - req_cyc, TO);
      end
      if (tx_wr_strobe) begin
        tx_count++;
        check("no_strobe_while_busy", {31'd0, prev_tx_busy}, 32'd0);
        if (exp_tx.size() == 0) begin
          check("unexpected_tx_strobe", 32'd1, 32'd0);
        end else begin
          exp_tx_t e;
          e = exp_tx.pop_front();
          $display("tx   #%0d data %02h (expect %02h) gap %0d (expect %0d)",
                   tx_count, tx_data, e.data, cyc - req_cyc, e.gap);
          check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
          check("tx_latency", cyc - req_cyc, e.gap);
        end
      end
    end
    prev_tx_busy = tx_busy;
  end

  task automatic wait_req(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (req_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("req_valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_exp(input logic [7:0] rq, input logic [7:0] tx, input int gap);
    exp_req.push_back(rq);
    exp_tx.push_back('{data: tx, gap: gap});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2;
    reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0;
    resp_data = 8'h00; resp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {14'd0, rx_rd_strobe, tx_wr_strobe, req_valid, busy, timeout_err, 5'd0, tx_data | req_data},
          32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: response three cycles after req_valid.
    push_exp(8'h41, 8'h61, 5);
    rx_data = 8'h41; rx_valid = 1'b1;
    wait_req(r1);
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1; resp_data = 8'h61; resp_valid = 1'b1;
    @(posedge clk); #1; resp_valid = 1'b0;
    wait_idle();

    // 2: minimum-latency response of 8'h00.
    push_exp(8'h42, 8'h00, 2);
    rx_data = 8'h42; rx_valid = 1'b1;
    wait_req(r1);
    rx_valid = 1'b0; resp_data = 8'h00; resp_valid = 1'b1;
    @(posedge clk); #1; resp_valid = 1'b0;
    wait_idle();

    // 3: no response, NAK after timeout.
    push_exp(8'h43, 8'h15, TO + 1);
    rx_data = 8'h43; rx_valid = 1'b1;
    wait_req(r1);
    rx_valid = 1'b0;
    wait_idle();
    check("timeout_count_after_t3", to_count, 1);

    // 4: tx_busy held for 20 cycles after the response.
    push_exp(8'h44, 8'h7e, 22);
    rx_data = 8'h44; rx_valid = 1'b1;
    wait_req(r1);
    rx_valid = 1'b0; resp_data = 8'h7e; resp_valid = 1'b1;
    @(posedge clk); #1; resp_valid = 1'b0; tx_busy = 1'b1;
    repeat (20) @(posedge clk);
    #1; tx_busy = 1'b0;
    wait_idle();

    // 5: second byte pending during the exchange is served after IDLE.
    push_exp(8'h5a, 8'ha1, 3);
    push_exp(8'hc3, 8'hb2, 2);
    rx_data = 8'h5a; rx_valid = 1'b1;
    wait_req(r1);
    rx_data = 8'hc3;
    @(posedge clk); #1; resp_data = 8'ha1; resp_valid = 1'b1;
    @(posedge clk); #1; resp_valid = 1'b0;
    wait_req(r2);
    check("back_to_back_spacing", r2 - r1, 5);
    rx_valid = 1'b0; resp_data = 8'hb2; resp_valid = 1'b1;
    @(posedge clk); #1; resp_valid = 1'b0;
    wait_idle();

    // 6: reset while held in TX_WAIT abandons the byte.
    exp_req.push_back(8'h77);
    rx_data = 8'h77; rx_valid = 1'b1;
    wait_req(r1);
    rx_valid = 1'b0; resp_data = 8'hee; resp_valid = 1'b1; tx_busy = 1'b1;
    @(posedge clk); #1; resp_valid = 1'b0;
    @(posedge clk); #1;
    check("busy_in_tx_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("outputs_after_mid_reset",
          {14'd0, rx_rd_strobe, tx_wr_strobe, req_valid, busy, timeout_err, 5'd0, tx_data | req_data},
          32'd0);
    reset = 1'b0; tx_busy = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    check("rd_strobe_count", rd_count, 7);
    check("req_valid_count", req_count, 7);
    check("tx_strobe_count", tx_count, 6);
    check("timeout_count", to_count, 1);
    check("req_queue_drained", exp_req.size(), 0);
    check("tx_queue_drained", exp_tx.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
